// File: rtl/bip_pkg.sv
// Shared definitions for the BIP controller: opcodes, accumulator-input
// select codes, FSM states and the decoded control bundle.
package bip_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_MEMORY = 2'b00;
  localparam logic [1:0] SEL_SIGNAL = 2'b01;
  localparam logic [1:0] SEL_ALU    = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } bip_state_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       halt;
  } bip_ctrl_t;

  localparam int CTRL_W = $bits(bip_ctrl_t);

  // Accumulator-input mux shared with the datapath.
  function automatic logic [15:0] acc_in_select(input logic [1:0]  sel,
                                                input logic [15:0] mem,
                                                input logic [15:0] sig,
                                                input logic [15:0] alu);
    case (sel)
      SEL_MEMORY: return mem;
      SEL_SIGNAL: return sig;
      SEL_ALU:    return alu;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/bip_decoder.sv
// Purely combinational opcode decoder; unknown opcodes decode as NOP.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl
);

  bip_ctrl_t c;

  always_comb begin
    c = '0;
    case (opcode)
      OP_HLT:  c.halt = 1'b1;
      OP_STO:  c.wr_ram = 1'b1;
      OP_LD: begin
        c.sel_a  = SEL_MEMORY;
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
      end
      OP_LDI: begin
        c.sel_a  = SEL_SIGNAL;
        c.wr_acc = 1'b1;
      end
      OP_ADD: begin
        c.sel_a  = SEL_ALU;
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
      end
      OP_ADDI: begin
        c.sel_a  = SEL_ALU;
        c.sel_b  = 1'b1;
        c.wr_acc = 1'b1;
      end
      OP_SUB: begin
        c.sel_a  = SEL_ALU;
        c.op     = 1'b1;
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
      end
      OP_SUBI: begin
        c.sel_a  = SEL_ALU;
        c.sel_b  = 1'b1;
        c.op     = 1'b1;
        c.wr_acc = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/bip_control.sv
// BIP sequencer: two-cycle FETCH/EXEC loop, program counter and a saturating
// retired-instruction counter.
//   state    | meaning
//   ST_FETCH | ROM read in flight, no strobes
//   ST_EXEC  | decode i_instruction, drive controls, advance pc on exit
//   ST_HALT  | stopped after HLT, left only by rst
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_LENGTH     = 11,
  parameter int DATA_LENGTH   = 16,
  parameter int RETIRED_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [DATA_LENGTH-1:0]   i_instruction,
  output logic [PC_LENGTH-1:0]     o_pc,
  output logic [1:0]               o_SelA,
  output logic                     o_SelB,
  output logic                     o_Op,
  output logic                     o_WrAcc,
  output logic                     o_WrRam,
  output logic                     o_RdRam,
  output logic [PC_LENGTH-1:0]     o_operand,
  output logic                     o_halted,
  output logic [RETIRED_WIDTH-1:0] o_retired
);

  bip_state_e               state_q, state_d;
  logic [PC_LENGTH-1:0]     pc_q;
  logic [RETIRED_WIDTH-1:0] retired_q;
  logic [CTRL_W-1:0]        dec_bits;
  bip_ctrl_t                dec;
  logic                     exec_exit;

  bip_decoder u_decoder (
    .opcode (i_instruction[DATA_LENGTH-1 -: OPCODE_W]),
    .ctrl   (dec_bits)
  );

  assign dec       = bip_ctrl_t'(dec_bits);
  assign exec_exit = (state_q == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      retired_q <= '0;
    end else if (i_enable) begin
      state_q <= state_d;
      if (exec_exit && !dec.halt)
        pc_q <= pc_q + 1'b1;
      if (exec_exit && (retired_q != '1))
        retired_q <= retired_q + 1'b1;
    end
  end

  // Controls are gated by enable so a frozen EXEC issues no strobes.
  always_comb begin
    state_d   = state_q;
    o_SelA    = SEL_MEMORY;
    o_SelB    = 1'b0;
    o_Op      = 1'b0;
    o_WrAcc   = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    o_operand = '0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d   = dec.halt ? ST_HALT : ST_FETCH;
        o_operand = i_instruction[PC_LENGTH-1:0];
        if (i_enable) begin
          o_SelA  = dec.sel_a;
          o_SelB  = dec.sel_b;
          o_Op    = dec.op;
          o_WrAcc = dec.wr_acc;
          o_WrRam = dec.wr_ram;
          o_RdRam = dec.rd_ram;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  assign o_pc      = pc_q;
  assign o_halted  = (state_q == ST_HALT);
  assign o_retired = retired_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: decode table plus hand-written sequences
// for enable freeze, pc wrap, reset priority and retired-counter saturation.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_instruction;
  logic [10:0] o_pc;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam, o_halted;
  logic [10:0] o_operand;
  logic [15:0] o_retired;

  logic        sat_en;
  logic [15:0] sat_instr;
  logic [10:0] sat_pc, sat_operand;
  logic [1:0]  sat_sela;
  logic        sat_selb, sat_op, sat_wracc, sat_wrram, sat_rdram, sat_halted;
  logic [3:0]  sat_retired;

  logic [15:0] rom [0:2047];

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] NOP = 16'h4000;

  always #5 clk = ~clk;

  // Registered program ROM: data valid one cycle after the address.
  always @(posedge clk) i_instruction <= rom[o_pc];

  bip_control dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_instruction(i_instruction),
    .o_pc(o_pc), .o_SelA(o_SelA), .o_SelB(o_SelB), .o_Op(o_Op),
    .o_WrAcc(o_WrAcc), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam),
    .o_operand(o_operand), .o_halted(o_halted), .o_retired(o_retired)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  bip_control #(.RETIRED_WIDTH(4)) sat_dut (
    .clk(clk), .rst(rst), .i_enable(sat_en), .i_instruction(sat_instr),
    .o_pc(sat_pc), .o_SelA(sat_sela), .o_SelB(sat_selb), .o_Op(sat_op),
    .o_WrAcc(sat_wracc), .o_WrRam(sat_wrram), .o_RdRam(sat_rdram),
    .o_operand(sat_operand), .o_halted(sat_halted), .o_retired(sat_retired)
  );

  typedef struct {
    logic [15:0] instr;
    logic [6:0]  strobes;   // {SelA, SelB, Op, WrAcc, WrRam, RdRam}
    logic        halt;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [6:0] strb();
    return {o_SelA, o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 2048; a++) rom[a] = NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_enable = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_enable = 1'b0;
    sat_en = 1'b0;
    sat_instr = NOP;
    fill_nop();

    vecs[0] = '{16'h0015, 7'b00_0_0_0_0_0, 1'b1};  // HLT
    vecs[1] = '{16'h0805, 7'b00_0_0_0_1_0, 1'b0};  // STO 5
    vecs[2] = '{16'h1009, 7'b00_0_0_1_0_1, 1'b0};  // LD 9
    vecs[3] = '{16'h1923, 7'b01_0_0_1_0_0, 1'b0};  // LDI 0x123
    vecs[4] = '{16'h2007, 7'b10_0_0_1_0_1, 1'b0};  // ADD 7
    vecs[5] = '{16'h2803, 7'b10_1_0_1_0_0, 1'b0};  // ADDI 3
    vecs[6] = '{16'h3001, 7'b10_0_1_1_0_1, 1'b0};  // SUB 1
    vecs[7] = '{16'h3802, 7'b10_1_1_1_0_0, 1'b0};  // SUBI 2
    vecs[8] = '{16'h42AA, 7'b00_0_0_0_0_0, 1'b0};  // NOP 01000
    vecs[9] = '{16'hFFFF, 7'b00_0_0_0_0_0, 1'b0};  // NOP 11111, operand 0x7FF

    step();
    step();

    // Decode table: one FETCH/EXEC pair per opcode from reset.
    for (int v = 0; v < 10; v++) begin
      rom[0] = vecs[v].instr;
      do_reset();
      chk($sformatf("v%0d rst_pc", v), o_pc, 0);
      chk($sformatf("v%0d fetch_strb", v), strb(), 0);
      chk($sformatf("v%0d rst_ret", v), o_retired, 0);
      step();
      chk($sformatf("v%0d exec_strb", v), strb(), vecs[v].strobes);
      chk($sformatf("v%0d exec_opnd", v), o_operand, {21'd0, vecs[v].instr[10:0]});
      step();
      chk($sformatf("v%0d pc_after", v), o_pc, vecs[v].halt ? 0 : 1);
      chk($sformatf("v%0d ret_after", v), o_retired, 1);
      chk($sformatf("v%0d halted", v), o_halted, vecs[v].halt);
      chk($sformatf("v%0d post_strb", v), strb(), 0);
    end

    // Program LDI 5, ADDI 3, STO 2, HLT.
    fill_nop();
    rom[0] = 16'h1805;
    rom[1] = 16'h2803;
    rom[2] = 16'h0802;
    rom[3] = 16'h0000;
    do_reset();
    begin
      logic [6:0] prog_exp [4];
      prog_exp[0] = 7'b01_0_0_1_0_0;
      prog_exp[1] = 7'b10_1_0_1_0_0;
      prog_exp[2] = 7'b00_0_0_0_1_0;
      prog_exp[3] = 7'b00_0_0_0_0_0;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("prog pc%0d", i), o_pc, i);
        step();
        chk($sformatf("prog strb%0d", i), strb(), prog_exp[i]);
        step();
      end
    end
    chk("prog halted", o_halted, 1);
    chk("prog retired", o_retired, 4);
    chk("prog pc_hold", o_pc, 3);
    step();
    step();
    chk("halt stays", o_halted, 1);
    chk("halt strb", strb(), 0);
    chk("halt retired", o_retired, 4);

    // Enable freeze during EXEC of ADD 7.
    fill_nop();
    rom[0] = 16'h2007;
    do_reset();
    step();
    chk("frz exec_strb", strb(), 7'b10_0_0_1_0_1);
    i_enable = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz strb%0d", i), strb(), 0);
      chk($sformatf("frz pc%0d", i), o_pc, 0);
      step();
    end
    chk("frz ret", o_retired, 0);
    i_enable = 1'b1;
    #1;
    chk("frz resume", strb(), 7'b10_0_0_1_0_1);
    step();
    chk("frz pc_inc", o_pc, 1);
    chk("frz ret_inc", o_retired, 1);

    // PC wrap after 2048 NOPs.
    fill_nop();
    do_reset();
    for (int i = 0; i < 2047; i++) begin
      step();
      step();
    end
    chk("wrap pc_top", o_pc, 11'h7FF);
    step();
    chk("wrap exec_strb", strb(), 0);
    step();
    chk("wrap pc_zero", o_pc, 0);
    chk("wrap retired", o_retired, 2048);

    // Reset mid-EXEC of STO 4.
    fill_nop();
    rom[0] = 16'h0804;
    do_reset();
    step();
    chk("rexec wrram", o_WrRam, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rexec pc", o_pc, 0);
    chk("rexec wrram0", o_WrRam, 0);
    chk("rexec halted", o_halted, 0);
    step();
    chk("rexec refetch", o_WrRam, 1);

    // Reset out of HALT, with enable low to show priority.
    rom[0] = 16'h0000;
    do_reset();
    step();
    step();
    chk("rhalt in_halt", o_halted, 1);
    i_enable = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rhalt halted0", o_halted, 0);
    chk("rhalt pc", o_pc, 0);
    chk("rhalt ret", o_retired, 0);
    chk("rhalt strb", strb(), 0);

    // Retired counter saturation on the narrow instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sat_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      step();
    end
    chk("sat 14", sat_retired, 4'hE);
    step();
    step();
    chk("sat 15", sat_retired, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      step();
    end
    chk("sat hold", sat_retired, 4'hF);
    chk("sat pc", sat_pc, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
